pn_eval: RTL and testbench
==========================

PN_EVAL -- requirements
Module: pn_eval

Interface
REQ-001 SHALL have parameter IN_W, default 3, meaning operand/operator code width in bits (>=2).
REQ-002 SHALL have parameter OUT_W, default 32, meaning signed result width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning max tokens per expression and stack depth.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode  input  2  notation: 00 prefix, 01 postfix, 10/11 illegal; sampled with first token.
REQ-007 SHALL have port operator  input  1  1 = token is operator, 0 = operand.
REQ-008 SHALL have port in  input  IN_W  operand value (unsigned) or operator code in[1:0]: 00 add, 01 sub, 10 mul, 11 absolute difference.
REQ-009 SHALL have port in_valid  input  1  token strobe; expression is contiguous high run.
REQ-010 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port out  output  OUT_W signed  result; 0 when out_valid low or err high.
REQ-012 SHALL have port err  output  1  malformed-expression flag, qualified by out_valid.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> EVAL -> DONE -> IDLE.
REQ-014 IDLE: in_valid=1 stores token 0, latches mode, goes to LOAD; in_valid=0 stays.
REQ-015 LOAD: each in_valid=1 cycle stores one token {operator,in} into buffer at incrementing index; first in_valid=0 sample goes to EVAL with N = stored count.
REQ-016 Tokens beyond DEPTH SHALL be discarded, N clamped to DEPTH, err set.
REQ-017 EVAL SHALL process exactly one token per cycle, N cycles: postfix in index order 0..N-1, prefix in reverse order N-1..0.
REQ-018 Operand: zero-extend to OUT_W, push.
REQ-019 Operator, prefix: a = pop (top), b = pop, push a op b; postfix: b = pop (top), a = pop, push a op b.
REQ-020 Arithmetic SHALL be two's complement, all results truncated to OUT_W (wrap, no saturation); mul keeps low OUT_W bits; abs difference = |a-b| truncated.
REQ-021 Stack underflow (operator with <2 entries) SHALL set err, push nothing, continue; evaluation length unchanged.
REQ-022 At end, stack count != 1 or illegal mode SHALL set err.
REQ-023 Latency: out_valid SHALL rise at clock edge k+N, edge k being first to sample in_valid=0 in LOAD; high exactly one cycle (DONE).
REQ-024 out = final stack top when err=0, else 0.
REQ-025 in_valid in EVAL/DONE SHALL be ignored; next expression accepted from IDLE only, earliest cycle after out_valid.
REQ-026 err, stack pointer, token count SHALL clear on entry to LOAD.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, out_valid=0, out=0, err=0, counters and stack pointer 0; reset mid-LOAD/EVAL abandons expression with no out_valid.
REQ-028 Buffer/stack contents need no reset.

Structure
REQ-029 Package pn_pkg SHALL hold mode encodings, operator encodings, FSM state type.
REQ-030 Combinational sub-module pn_alu (a, b, op -> OUT_W result) SHALL implement REQ-020.
REQ-031 Buffer and stack SHALL be DEPTH-entry register arrays; stack pointer width clog2(DEPTH+1).

Verification
REQ-032 Prefix [sub, mul, 3, 4, 5] -> out_valid 5 cycles after in_valid falls, out=7, err=0.
REQ-033 Postfix [3, 4, 5, mul, sub] -> out=-17, err=0.
REQ-034 Postfix [2, 7, absdiff] -> out=5; prefix [absdiff, 2, 7] -> out=5.
REQ-035 Prefix [add, 3] -> err=1, out=0, out_valid after 2 cycles; mode=10 with [3] -> err=1.
REQ-036 OUT_W=8, postfix [7,7,mul,7,mul,7,mul] -> out=97 (2401 mod 256), err=0.
REQ-037 DEPTH=16, 17 operands -> err=1 after 16 eval cycles; rst_n pulse mid-EVAL -> no out_valid, next expression correct.

Source files
------------

// File: rtl/pn_pkg.sv
// Shared encodings for the prefix/postfix expression evaluator.
package pn_pkg;

    localparam logic [1:0] MODE_PREFIX  = 2'b00;
    localparam logic [1:0] MODE_POSTFIX = 2'b01;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_MUL     = 2'b10,
        OP_ABSDIFF = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_EVAL = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/pn_alu.sv
// Combinational wrap-around ALU: add, sub, mul (low bits), absolute difference.
module pn_alu
    import pn_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic signed [OUT_W-1:0] a_i,
    input  logic signed [OUT_W-1:0] b_i,
    input  op_e                     op_i,
    output logic signed [OUT_W-1:0] res_o
);

    logic signed [OUT_W:0] diff_c;

    always_comb begin
        // one extra bit keeps |a-b| exact before truncation
        diff_c = {a_i[OUT_W-1], a_i} - {b_i[OUT_W-1], b_i};
        res_o  = '0;
        unique case (op_i)
            OP_ADD:     res_o = a_i + b_i;
            OP_SUB:     res_o = a_i - b_i;
            OP_MUL:     res_o = a_i * b_i;
            OP_ABSDIFF: res_o = diff_c[OUT_W] ? OUT_W'(-diff_c) : diff_c[OUT_W-1:0];
            default:    res_o = '0;
        endcase
    end

endmodule

// File: rtl/pn_eval.sv
// Prefix/postfix expression evaluator: buffers a token run, then evaluates
// one token per cycle on a register stack and reports a one-cycle result.
module pn_eval
    import pn_pkg::*;
#(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    operator,
    input  logic [IN_W-1:0]         in,
    input  logic                    in_valid,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out,
    output logic                    err
);

    localparam int unsigned TOK_W = IN_W + 1;
    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] DEPTH_C = SP_W'(DEPTH);

    state_e                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [SP_W-1:0]         cnt_q, cnt_d;
    logic [SP_W-1:0]         rem_q, rem_d;
    logic [SP_W-1:0]         sp_q, sp_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    out_err_q, out_err_d;

    logic [TOK_W-1:0]        buf_q [DEPTH];
    logic signed [OUT_W-1:0] stk_q [DEPTH];

    logic                    buf_we;
    logic [IDX_W-1:0]        buf_waddr;
    logic                    stk_we;
    logic [IDX_W-1:0]        stk_waddr;

    logic [TOK_W-1:0]        tok_c;
    logic                    tok_is_op_c;
    logic                    prefix_c;
    logic                    mode_bad_c;
    logic signed [OUT_W-1:0] top_c, nxt_c, alu_a_c, alu_b_c, alu_res_c, push_val_c;

    // Current token, stack operands and the value it would push
    always_comb begin
        tok_c       = buf_q[idx_q];
        tok_is_op_c = tok_c[IN_W];
        prefix_c    = (mode_q == MODE_PREFIX);
        mode_bad_c  = (mode_q != MODE_PREFIX) && (mode_q != MODE_POSTFIX);
        top_c       = stk_q[IDX_W'(sp_q - SP_W'(1))];
        nxt_c       = stk_q[IDX_W'(sp_q - SP_W'(2))];
        alu_a_c     = prefix_c ? top_c : nxt_c;
        alu_b_c     = prefix_c ? nxt_c : top_c;
        push_val_c  = tok_is_op_c ? alu_res_c : OUT_W'(tok_c[IN_W-1:0]);
    end

    pn_alu #(.OUT_W(OUT_W)) u_alu (
        .a_i  (alu_a_c),
        .b_i  (alu_b_c),
        .op_i (op_e'(tok_c[1:0])),
        .res_o(alu_res_c)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        sp_d        = sp_q;
        idx_d       = idx_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_d       = '0;
        out_err_d   = 1'b0;
        buf_we      = 1'b0;
        buf_waddr   = '0;
        stk_we      = 1'b0;
        stk_waddr   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    buf_we  = 1'b1;
                    mode_d  = mode;
                    cnt_d   = SP_W'(1);
                    sp_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q < DEPTH_C) begin
                        buf_we    = 1'b1;
                        buf_waddr = IDX_W'(cnt_q);
                        cnt_d     = cnt_q + SP_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    rem_d   = cnt_q;
                    idx_d   = prefix_c ? IDX_W'(cnt_q - SP_W'(1)) : '0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (tok_is_op_c) begin
                    if (sp_q < SP_W'(2)) begin
                        err_d = 1'b1;
                    end else begin
                        stk_we    = 1'b1;
                        stk_waddr = IDX_W'(sp_q - SP_W'(2));
                        sp_d      = sp_q - SP_W'(1);
                    end
                end else begin
                    stk_we    = 1'b1;
                    stk_waddr = IDX_W'(sp_q);
                    sp_d      = sp_q + SP_W'(1);
                end
                idx_d = prefix_c ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
                rem_d = rem_q - SP_W'(1);
                // last token: the value pushed now is the final stack top
                if (rem_q == SP_W'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_err_d   = err_d | (sp_d != SP_W'(1)) | mode_bad_c;
                    out_d       = out_err_d ? '0 : push_val_c;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            sp_q        <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            sp_q        <= sp_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_err_q   <= out_err_d;
        end
    end

    // Token buffer and operand stack hold data only; no reset needed
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[buf_waddr] <= {operator, in};
        if (stk_we) stk_q[stk_waddr] <= push_val_c;
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign err       = out_err_q;

endmodule

// File: tb/tb_pn_eval.sv
// Scoreboard bench for pn_eval: one stimulus stream drives a 32-bit and an 8-bit instance.
module tb_pn_eval;

    localparam int unsigned IN_W  = 3;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic op_s = 1'b0;
    logic [IN_W-1:0] tin = '0;
    logic in_valid = 1'b0;

    logic               ov32, err32;
    logic signed [31:0] out32;
    logic               ov8, err8;
    logic signed [7:0]  out8;

    typedef struct {
        bit     err;
        longint val;
        int     cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int tok[64];
    int ntok = 0;
    int tq[$];

    pn_eval #(.IN_W(IN_W), .OUT_W(32), .DEPTH(DEPTH)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .operator(op_s), .in(tin),
        .in_valid(in_valid), .out_valid(ov32), .out(out32), .err(err32)
    );

    pn_eval #(.IN_W(IN_W), .OUT_W(8), .DEPTH(DEPTH)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .operator(op_s), .in(tin),
        .in_valid(in_valid), .out_valid(ov8), .out(out8), .err(err8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic longint wrapw(input longint x, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = x & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    // Reference: tokens 0..99 are operands, 100+code are operators
    function automatic void model(input logic [1:0] m, input int w, output bit e, output longint v);
        longint st[$];
        longint x, y, a, b, r;
        int n, t;
        bit pre;
        n   = (ntok > DEPTH) ? DEPTH : ntok;
        e   = (ntok > DEPTH) || (m > 2'd1);
        pre = (m == 2'd0);
        for (int j = 0; j < n; j++) begin
            t = pre ? tok[n-1-j] : tok[j];
            if (t < 100) begin
                st.push_back(wrapw(longint'(t), w));
            end else if (st.size() < 2) begin
                e = 1'b1;
            end else begin
                x = st.pop_back();
                y = st.pop_back();
                a = pre ? x : y;
                b = pre ? y : x;
                case ((t - 100) % 4)
                    0:       r = a + b;
                    1:       r = a - b;
                    2:       r = a * b;
                    default: r = (a > b) ? a - b : b - a;
                endcase
                st.push_back(wrapw(r, w));
            end
        end
        if (st.size() != 1) e = 1'b1;
        v = e ? 0 : st[0];
    endfunction

    task automatic push_exp(input logic [1:0] m, input int exp_cyc);
        exp_t e;
        model(m, 32, e.err, e.val);
        e.cyc = exp_cyc;
        q32.push_back(e);
        model(m, 8, e.err, e.val);
        q8.push_back(e);
    endtask

    task automatic load_tq();
        ntok = tq.size();
        for (int i = 0; i < ntok; i++) tok[i] = tq[i];
    endtask

    task automatic drive_tokens(input logic [1:0] m);
        for (int i = 0; i < ntok; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            op_s     = (tok[i] >= 100);
            tin      = IN_W'((tok[i] >= 100) ? tok[i] - 100 : tok[i]);
            mode     = (i == 0) ? m : 2'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_s     = 1'($urandom);
        tin      = IN_W'($urandom);
    endtask

    task automatic run_expr(input logic [1:0] m, input bit junk);
        int n;
        drive_tokens(m);
        n = (ntok > DEPTH) ? DEPTH : ntok;
        push_exp(m, cyc + 1 + n);
        @(posedge clk);
        // tokens offered during EVAL/DONE must be ignored
        for (int i = 0; i <= n; i++) begin
            #1;
            in_valid = junk ? 1'($urandom) : 1'b0;
            op_s     = 1'($urandom);
            tin      = IN_W'($urandom);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic reset_mid_eval();
        drive_tokens(2'b00);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ov32", longint'(ov32), 0);
        chk("rst_out32", longint'(out32), 0);
        chk("rst_err32", longint'(err32), 0);
        chk("rst_ov8", longint'(ov8), 0);
        #2 rst_n = 1'b1;
        repeat (ntok + 4) @(posedge clk);
        #1;
    endtask

    task automatic gen_rand(output logic [1:0] m);
        int len, depth, i, t;
        len = $urandom_range(1, 18);
        if ($urandom_range(0, 3) == 0) begin
            for (i = 0; i < len; i++)
                tok[i] = ($urandom_range(0, 1) == 1) ? 100 + $urandom_range(0, 7) : $urandom_range(0, 7);
            ntok = len;
        end else begin
            depth = 0;
            i = 0;
            while ((i < len || depth > 1) && i < 24) begin
                if (depth >= 2 && (i >= len || $urandom_range(0, 1) == 1)) begin
                    tok[i] = 100 + $urandom_range(0, 7);
                    depth--;
                end else begin
                    tok[i] = $urandom_range(0, 7);
                    depth++;
                end
                i++;
            end
            ntok = i;
        end
        m = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        if (m == 2'b00) begin
            for (int j = 0; j < ntok / 2; j++) begin
                t = tok[j];
                tok[j] = tok[ntok-1-j];
                tok[ntok-1-j] = t;
            end
        end
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (ov32) begin
            if (q32.size() == 0) begin
                chk("spurious32", longint'(ov32), 0);
            end else begin
                e = q32.pop_front();
                chk("out32", longint'(out32), e.val);
                chk("err32", longint'(err32), longint'(e.err));
                chk("lat32", longint'(cyc), longint'(e.cyc));
            end
        end else begin
            chk("idle_out32", longint'(out32), 0);
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (ov8) begin
            if (q8.size() == 0) begin
                chk("spurious8", longint'(ov8), 0);
            end else begin
                e = q8.pop_front();
                chk("out8", longint'(out8), e.val);
                chk("err8", longint'(err8), longint'(e.err));
                chk("lat8", longint'(cyc), longint'(e.cyc));
            end
        end else begin
            chk("idle_out8", longint'(out8), 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 200000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [1:0] m;
        #12;
        chk("reset_ov", longint'(ov32), 0);
        chk("reset_out", longint'(out32), 0);
        chk("reset_err", longint'(err32), 0);
        @(negedge clk) rst_n = 1'b1;

        tq = '{101, 102, 3, 4, 5};           load_tq(); run_expr(2'b00, 1'b0);
        tq = '{3, 4, 5, 102, 101};           load_tq(); run_expr(2'b01, 1'b0);
        tq = '{2, 7, 103};                   load_tq(); run_expr(2'b01, 1'b1);
        tq = '{103, 2, 7};                   load_tq(); run_expr(2'b00, 1'b1);
        tq = '{100, 3};                      load_tq(); run_expr(2'b00, 1'b0);
        tq = '{3};                           load_tq(); run_expr(2'b10, 1'b0);
        tq = '{7, 7, 102, 7, 102, 7, 102};   load_tq(); run_expr(2'b01, 1'b0);
        tq = '{107, 5};                      load_tq(); run_expr(2'b01, 1'b0);

        ntok = 17;
        for (int i = 0; i < 17; i++) tok[i] = i % 8;
        run_expr(2'b01, 1'b0);

        tq = '{101, 102, 3, 4, 5};           load_tq(); reset_mid_eval();
        tq = '{101, 102, 3, 4, 5};           load_tq(); run_expr(2'b00, 1'b0);

        for (int k = 0; k < 60; k++) begin
            gen_rand(m);
            run_expr(m, 1'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("pending32", longint'(q32.size()), 0);
        chk("pending8", longint'(q8.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
